// File: rtl/mem_lsu_hs.sv
// Multi-cycle MEM-stage load/store unit: req/ack/err data-bus handshake, pipeline stall,
// misaligned/bus-error/timeout exceptions and fixed-priority interrupt arbitration.
module mem_lsu_hs #(
  parameter int unsigned NUM_IRQ = 3,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  input  logic [3:0]             op_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            wdata_i,
  input  logic                   flush_i,
  input  logic [NUM_IRQ-1:0]     irq_i,
  input  logic [31*NUM_IRQ-1:0]  irq_code_i,
  output logic                   bus_req_o,
  output logic                   bus_we_o,
  output logic [3:0]             bus_sel_o,
  output logic [ADDR_W-1:0]      bus_addr_o,
  output logic [31:0]            bus_wdata_o,
  input  logic                   bus_ack_i,
  input  logic                   bus_err_i,
  input  logic [31:0]            bus_rdata_i,
  output logic                   stall_o,
  output logic                   done_o,
  output logic [31:0]            rdata_o,
  output logic [31:0]            exc_o,
  output logic [31:0]            tval_o
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd9;
  localparam logic [3:0] OP_SH  = 4'd10;
  localparam logic [3:0] OP_SW  = 4'd11;

  localparam logic [31:0] EXC_LD_MIS = 32'd4;
  localparam logic [31:0] EXC_LD_ERR = 32'd5;
  localparam logic [31:0] EXC_ST_MIS = 32'd6;
  localparam logic [31:0] EXC_ST_ERR = 32'd7;

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_ABORT} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          op_q, op_d;
  logic [31:0]         addr_q, addr_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [3:0]          bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [31:0]         bus_wdata_q, bus_wdata_d;
  logic                done_q, done_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [31:0]         exc_q, exc_d;
  logic [31:0]         tval_q, tval_d;

  logic        is_load, is_store, is_mem, misaligned;
  logic        irq_any, irq_found, accept, bus_end;
  logic [30:0] irq_code;

  // Big-endian lanes: byte offset 0 lives in bits [31:24].
  function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] a);
    case (op)
      OP_LB, OP_LBU, OP_SB: lane_sel = 4'b1000 >> a;
      OP_LH, OP_LHU, OP_SH: lane_sel = a[1] ? 4'b0011 : 4'b1100;
      default:              lane_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] wd);
    case (op)
      OP_SB:   store_data = {4{wd[7:0]}};
      OP_SH:   store_data = {2{wd[15:0]}};
      OP_SW:   store_data = wd;
      default: store_data = '0;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'b00:   b = rd[31:24];
      2'b01:   b = rd[23:16];
      2'b10:   b = rd[15:8];
      default: b = rd[7:0];
    endcase
    h = a[1] ? rd[15:0] : rd[31:16];
    case (op)
      OP_LB:   load_ext = {{24{b[7]}}, b};
      OP_LBU:  load_ext = {24'd0, b};
      OP_LH:   load_ext = {{16{h[15]}}, h};
      OP_LHU:  load_ext = {16'd0, h};
      OP_LW:   load_ext = rd;
      default: load_ext = '0;
    endcase
  endfunction

  always_comb begin
    is_load  = (op_i >= OP_LB) && (op_i <= OP_LW);
    is_store = (op_i >= OP_SB) && (op_i <= OP_SW);
    is_mem   = is_load | is_store;
    case (op_i)
      OP_LH, OP_LHU, OP_SH: misaligned = addr_i[0];
      OP_LW, OP_SW:         misaligned = |addr_i[1:0];
      default:              misaligned = 1'b0;
    endcase
    irq_any   = |irq_i;
    irq_found = 1'b0;
    irq_code  = '0;
    for (int unsigned k = 0; k < NUM_IRQ; k++) begin
      if (irq_i[k] && !irq_found) begin
        irq_found = 1'b1;
        irq_code  = irq_code_i[31*k +: 31];
      end
    end
    accept  = (state_q == S_IDLE) && valid_i && !flush_i;
    bus_end = bus_err_i | bus_ack_i | (cnt_q == CNT_W'(TIMEOUT));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_d      = addr_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    done_d      = 1'b0;
    rdata_d     = '0;
    exc_d       = '0;
    tval_d      = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (irq_any) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            exc_d   = {1'b1, irq_code};
          end else if (misaligned) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            exc_d   = is_store ? EXC_ST_MIS : EXC_LD_MIS;
            tval_d  = addr_i;
          end else if (is_mem) begin
            state_d     = S_BUSY;
            cnt_d       = CNT_W'(1);
            op_d        = op_i;
            addr_d      = addr_i;
            bus_req_d   = 1'b1;
            bus_we_d    = is_store;
            bus_sel_d   = lane_sel(op_i, addr_i[1:0]);
            bus_addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
            bus_wdata_d = store_data(op_i, wdata_i);
          end
        end
      end
      S_BUSY, S_ABORT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_end) begin
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_sel_d   = '0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
          state_d     = S_IDLE;
          // An aborted (or same-cycle flushed) access still completes on the bus but reports nothing.
          if (state_q == S_BUSY && !flush_i) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            if (bus_ack_i && !bus_err_i) begin
              rdata_d = load_ext(op_q, addr_q[1:0], bus_rdata_i);
            end else begin
              exc_d  = op_q[3] ? EXC_ST_ERR : EXC_LD_ERR;
              tval_d = addr_q;
            end
          end
        end else if (state_q == S_BUSY && flush_i) begin
          state_d = S_ABORT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      addr_q      <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      exc_q       <= '0;
      tval_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      exc_q       <= exc_d;
      tval_q      <= tval_d;
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign stall_o     = (state_q == S_BUSY) | (accept & (irq_any | is_mem));
  assign done_o      = done_q & ~flush_i;
  assign exc_o       = flush_i ? '0 : exc_q;
  assign rdata_o     = rdata_q;
  assign tval_o      = tval_q;

endmodule

// File: tb/tb_mem_lsu_hs.sv
// Directed bench for mem_lsu_hs: a vector table for single accesses plus hand sequences
// for timeout, flush and reset corner cases.
module tb_mem_lsu_hs;

  logic        clk = 1'b0;
  logic        rst, valid_i, flush_i;
  logic [3:0]  op_i;
  logic [31:0] addr_i, wdata_i;
  logic [2:0]  irq_i;
  logic [92:0] irq_code_i;
  logic        bus_req_o, bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic        bus_ack_i, bus_err_i;
  logic [31:0] bus_rdata_i;
  logic        stall_o, done_o;
  logic [31:0] rdata_o, exc_o, tval_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_lsu_hs #(.NUM_IRQ(3), .TIMEOUT(16), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .flush_i(flush_i), .irq_i(irq_i), .irq_code_i(irq_code_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
    .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i), .stall_o(stall_o),
    .done_o(done_o), .rdata_o(rdata_o), .exc_o(exc_o), .tval_o(tval_o)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  irq;
    int          kind;   // 0 ignored, 1 bus access, 2 immediate exception
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] res;
    logic [31:0] exc;
    logic [31:0] tval;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input string name, input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] irq, input int kind,
                              input logic ack, input logic err, input logic [31:0] rdata,
                              input logic we, input logic [3:0] sel, input logic [31:0] baddr,
                              input logic [31:0] bwdata, input logic [31:0] res,
                              input logic [31:0] exc, input logic [31:0] tval);
    vec_t v;
    v.name = name; v.op = op; v.addr = addr; v.wdata = wdata; v.irq = irq; v.kind = kind;
    v.ack = ack; v.err = err; v.rdata = rdata; v.we = we; v.sel = sel; v.baddr = baddr;
    v.bwdata = bwdata; v.res = res; v.exc = exc; v.tval = tval;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v);
    valid_i = 1'b1; op_i = v.op; addr_i = v.addr; wdata_i = v.wdata; irq_i = v.irq;
    #1;
    chk({v.name, " accept_stall"}, {31'd0, stall_o}, {31'd0, v.kind != 0});
    tick();
    valid_i = 1'b0; op_i = '0; irq_i = '0; wdata_i = '0;
    if (v.kind == 1) begin
      chk({v.name, " req"}, {31'd0, bus_req_o}, 32'd1);
      chk({v.name, " we"}, {31'd0, bus_we_o}, {31'd0, v.we});
      chk({v.name, " sel"}, {28'd0, bus_sel_o}, {28'd0, v.sel});
      chk({v.name, " baddr"}, bus_addr_o, v.baddr);
      chk({v.name, " bwdata"}, bus_wdata_o, v.bwdata);
      chk({v.name, " busy_stall"}, {31'd0, stall_o}, 32'd1);
      bus_ack_i = v.ack; bus_err_i = v.err; bus_rdata_i = v.rdata;
      tick();
      bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;
      chk({v.name, " req_drop"}, {31'd0, bus_req_o}, 32'd0);
      chk({v.name, " done_stall"}, {31'd0, stall_o}, 32'd0);
    end else begin
      chk({v.name, " no_req"}, {31'd0, bus_req_o}, 32'd0);
    end
    chk({v.name, " done"}, {31'd0, done_o}, {31'd0, v.kind != 0});
    if (v.kind != 0) begin
      chk({v.name, " rdata"}, rdata_o, v.res);
      chk({v.name, " exc"}, exc_o, v.exc);
      chk({v.name, " tval"}, tval_o, v.tval);
    end
    tick();
    chk({v.name, " done_clear"}, {31'd0, done_o}, 32'd0);
    chk({v.name, " exc_clear"}, exc_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic unstable;

    vecs[0]  = mk("lb_neg",  4'd1, 32'h103, 32'h0, 3'b000, 1, 1, 0, 32'h000000F0, 0, 4'b0001, 32'h100, 32'h0, 32'hFFFFFFF0, 32'h0, 32'h0);
    vecs[1]  = mk("lbu",     4'd2, 32'h102, 32'h0, 3'b000, 1, 1, 0, 32'h1234F600, 0, 4'b0010, 32'h100, 32'h0, 32'h000000F6, 32'h0, 32'h0);
    vecs[2]  = mk("lh_neg",  4'd3, 32'h200, 32'h0, 3'b000, 1, 1, 0, 32'h80011234, 0, 4'b1100, 32'h200, 32'h0, 32'hFFFF8001, 32'h0, 32'h0);
    vecs[3]  = mk("lhu",     4'd4, 32'h202, 32'h0, 3'b000, 1, 1, 0, 32'h12349ABC, 0, 4'b0011, 32'h200, 32'h0, 32'h00009ABC, 32'h0, 32'h0);
    vecs[4]  = mk("lw",      4'd5, 32'h304, 32'h0, 3'b000, 1, 1, 0, 32'hDEADBEEF, 0, 4'b1111, 32'h304, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0);
    vecs[5]  = mk("lb_pos",  4'd1, 32'h000, 32'h0, 3'b000, 1, 1, 0, 32'h7F000000, 0, 4'b1000, 32'h000, 32'h0, 32'h0000007F, 32'h0, 32'h0);
    vecs[6]  = mk("sh",      4'd10, 32'h202, 32'h1234ABCD, 3'b000, 1, 1, 0, 32'hFFFFFFFF, 1, 4'b0011, 32'h200, 32'hABCDABCD, 32'h0, 32'h0, 32'h0);
    vecs[7]  = mk("sb",      4'd9, 32'h101, 32'h000000A5, 3'b000, 1, 1, 0, 32'h0, 1, 4'b0100, 32'h100, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0);
    vecs[8]  = mk("sw",      4'd11, 32'h400, 32'hCAFEF00D, 3'b000, 1, 1, 0, 32'h0, 1, 4'b1111, 32'h400, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0);
    vecs[9]  = mk("lw_err",  4'd5, 32'h800, 32'h0, 3'b000, 1, 0, 1, 32'h55555555, 0, 4'b1111, 32'h800, 32'h0, 32'h0, 32'h5, 32'h800);
    vecs[10] = mk("sb_errack", 4'd9, 32'h801, 32'h000000C3, 3'b000, 1, 1, 1, 32'h0, 1, 4'b0100, 32'h800, 32'hC3C3C3C3, 32'h0, 32'h7, 32'h801);
    vecs[11] = mk("lw_mis",  4'd5, 32'h101, 32'h0, 3'b000, 2, 0, 0, 32'h0, 0, 4'b0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h101);
    vecs[12] = mk("sh_mis",  4'd10, 32'h203, 32'h0, 3'b000, 2, 0, 0, 32'h0, 0, 4'b0, 32'h0, 32'h0, 32'h0, 32'h6, 32'h203);
    vecs[13] = mk("lhu_mis", 4'd4, 32'h001, 32'h0, 3'b000, 2, 0, 0, 32'h0, 0, 4'b0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h001);
    vecs[14] = mk("sw_mis",  4'd11, 32'h102, 32'h0, 3'b000, 2, 0, 0, 32'h0, 0, 4'b0, 32'h0, 32'h0, 32'h0, 32'h6, 32'h102);
    vecs[15] = mk("irq_110", 4'd5, 32'h100, 32'h0, 3'b110, 2, 0, 0, 32'h0, 0, 4'b0, 32'h0, 32'h0, 32'h0, 32'h8000000B, 32'h0);
    vecs[16] = mk("irq_001", 4'd1, 32'h100, 32'h0, 3'b001, 2, 0, 0, 32'h0, 0, 4'b0, 32'h0, 32'h0, 32'h0, 32'h80000003, 32'h0);
    vecs[17] = mk("irq_100", 4'd0, 32'h100, 32'h0, 3'b100, 2, 0, 0, 32'h0, 0, 4'b0, 32'h0, 32'h0, 32'h0, 32'h80000007, 32'h0);
    vecs[18] = mk("irq_mis", 4'd5, 32'h101, 32'h0, 3'b010, 2, 0, 0, 32'h0, 0, 4'b0, 32'h0, 32'h0, 32'h0, 32'h8000000B, 32'h0);
    vecs[19] = mk("op0",     4'd0, 32'h100, 32'h0, 3'b000, 0, 0, 0, 32'h0, 0, 4'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[20] = mk("op7",     4'd7, 32'h104, 32'h0, 3'b000, 0, 0, 0, 32'h0, 0, 4'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[21] = mk("op15",    4'd15, 32'h108, 32'h0, 3'b000, 0, 0, 0, 32'h0, 0, 4'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; op_i = '0; addr_i = '0; wdata_i = '0;
    irq_i = '0; irq_code_i = {31'd7, 31'd11, 31'd3};
    bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst req", {31'd0, bus_req_o}, 32'd0);
    chk("rst stall", {31'd0, stall_o}, 32'd0);
    chk("rst done", {31'd0, done_o}, 32'd0);
    chk("rst outs", rdata_o | exc_o | tval_o | bus_addr_o | bus_wdata_o, 32'd0);
    tick();

    for (int i = 0; i < 22; i++) apply_vec(vecs[i]);

    // Timeout on a store with no ack.
    valid_i = 1'b1; op_i = 4'd11; addr_i = 32'h700; wdata_i = 32'h11223344;
    #1 chk("to accept_stall", {31'd0, stall_o}, 32'd1);
    tick();
    valid_i = 1'b0; op_i = '0; wdata_i = '0;
    n = 0; unstable = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!bus_req_o) break;
      n++;
      if (bus_addr_o !== 32'h700 || bus_we_o !== 1'b1 || bus_wdata_o !== 32'h11223344 ||
          bus_sel_o !== 4'b1111 || stall_o !== 1'b1) unstable = 1'b1;
      tick();
    end
    chk("to req_cycles", n, 32'd16);
    chk("to stable", {31'd0, unstable}, 32'd0);
    chk("to done", {31'd0, done_o}, 32'd1);
    chk("to exc", exc_o, 32'h7);
    chk("to tval", tval_o, 32'h700);
    chk("to stall", {31'd0, stall_o}, 32'd0);
    tick();
    chk("to done_clear", {31'd0, done_o}, 32'd0);

    // Flush while BUSY: handshake completes, nothing reported.
    valid_i = 1'b1; op_i = 4'd5; addr_i = 32'h500;
    tick();
    valid_i = 1'b0; op_i = '0;
    chk("fb req", {31'd0, bus_req_o}, 32'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fb abort_stall", {31'd0, stall_o}, 32'd0);
    chk("fb abort_req1", {31'd0, bus_req_o}, 32'd1);
    tick();
    chk("fb abort_req2", {31'd0, bus_req_o}, 32'd1);
    tick();
    chk("fb abort_req3", {31'd0, bus_req_o}, 32'd1);
    chk("fb abort_addr", bus_addr_o, 32'h500);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h12345678;
    tick();
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    chk("fb req_drop", {31'd0, bus_req_o}, 32'd0);
    chk("fb no_done", {31'd0, done_o}, 32'd0);
    chk("fb no_rdata", rdata_o, 32'd0);
    tick();
    chk("fb no_done2", {31'd0, done_o}, 32'd0);
    apply_vec(vecs[4]);

    // Reset mid-access.
    valid_i = 1'b1; op_i = 4'd5; addr_i = 32'h600;
    tick();
    valid_i = 1'b0; op_i = '0;
    chk("rb req", {31'd0, bus_req_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rb req", {31'd0, bus_req_o}, 32'd0);
    chk("rb stall", {31'd0, stall_o}, 32'd0);
    chk("rb sel_addr", {28'd0, bus_sel_o} | bus_addr_o, 32'd0);
    chk("rb done", {31'd0, done_o}, 32'd0);
    bus_ack_i = 1'b1;
    tick();
    bus_ack_i = 1'b0;
    chk("rb late_ack_done", {31'd0, done_o}, 32'd0);
    chk("rb late_ack_req", {31'd0, bus_req_o}, 32'd0);

    // Flush during DONE masks the result.
    valid_i = 1'b1; op_i = 4'd5; addr_i = 32'h101;
    tick();
    valid_i = 1'b0; op_i = '0;
    flush_i = 1'b1;
    #1;
    chk("fd done", {31'd0, done_o}, 32'd0);
    chk("fd exc", exc_o, 32'd0);
    flush_i = 1'b0;
    tick();
    chk("fd done_after", {31'd0, done_o}, 32'd0);

    // Flush in IDLE blocks acceptance.
    valid_i = 1'b1; op_i = 4'd5; addr_i = 32'h900; flush_i = 1'b1;
    #1 chk("fi stall", {31'd0, stall_o}, 32'd0);
    tick();
    valid_i = 1'b0; op_i = '0; flush_i = 1'b0;
    chk("fi req", {31'd0, bus_req_o}, 32'd0);
    chk("fi done", {31'd0, done_o}, 32'd0);

    // No accept while in DONE.
    valid_i = 1'b1; op_i = 4'd3; addr_i = 32'h201;
    tick();
    op_i = 4'd5; addr_i = 32'hA00;
    #1;
    chk("nd stall", {31'd0, stall_o}, 32'd0);
    chk("nd done", {31'd0, done_o}, 32'd1);
    chk("nd exc", exc_o, 32'h4);
    tick();
    valid_i = 1'b0; op_i = '0;
    chk("nd req", {31'd0, bus_req_o}, 32'd0);
    chk("nd done_clear", {31'd0, done_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
